// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-stage forwarding muxes, branch target and redirect decision.
// Registered fields move one cycle from D to E; ALU operands and PC redirect are combinational from E state.
module id_ex_stage #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               FlushE,
  input  logic               StallE,
  input  logic [WIDTH-1:0]   RD1D,
  input  logic [WIDTH-1:0]   RD2D,
  input  logic [WIDTH-1:0]   ImmExtD,
  input  logic [WIDTH-1:0]   PCD,
  input  logic [WIDTH-1:0]   PCPlus4D,
  input  logic [REGADDR-1:0] Rs1D,
  input  logic [REGADDR-1:0] Rs2D,
  input  logic [REGADDR-1:0] RdD,
  input  logic               RegWriteD,
  input  logic               MemWriteD,
  input  logic               JumpD,
  input  logic               BranchD,
  input  logic               ALUSrcD,
  input  logic [1:0]         ResultSrcD,
  input  logic [2:0]         ALUControlD,
  input  logic [1:0]         ForwardAE,
  input  logic [1:0]         ForwardBE,
  input  logic [WIDTH-1:0]   ALUResultM,
  input  logic [WIDTH-1:0]   ResultW,
  input  logic               ZeroE,
  output logic [WIDTH-1:0]   SrcAE,
  output logic [WIDTH-1:0]   SrcBE,
  output logic [2:0]         ALUControlE,
  output logic [WIDTH-1:0]   WriteDataE,
  output logic [WIDTH-1:0]   PCTargetE,
  output logic               PCSrcE,
  output logic [REGADDR-1:0] RdE,
  output logic [REGADDR-1:0] Rs1E,
  output logic [REGADDR-1:0] Rs2E,
  output logic [WIDTH-1:0]   PCPlus4E,
  output logic               RegWriteE,
  output logic               MemWriteE,
  output logic [1:0]         ResultSrcE,
  output logic               ValidE
);

  logic [WIDTH-1:0]   rd1_r;
  logic [WIDTH-1:0]   rd2_r;
  logic [WIDTH-1:0]   imm_r;
  logic [WIDTH-1:0]   pc_r;
  logic [WIDTH-1:0]   pcplus4_r;
  logic [REGADDR-1:0] rs1_r;
  logic [REGADDR-1:0] rs2_r;
  logic [REGADDR-1:0] rd_r;
  logic               regwrite_r;
  logic               memwrite_r;
  logic               jump_r;
  logic               branch_r;
  logic               alusrc_r;
  logic [1:0]         resultsrc_r;
  logic [2:0]         aluctrl_r;
  logic               valid_r;

  logic [WIDTH-1:0]   fwd_a_s;
  logic [WIDTH-1:0]   fwd_b_s;
  logic [WIDTH-1:0]   srcb_s;
  logic [WIDTH-1:0]   target_s;
  logic               pcsrc_s;

  // Forwarding select; the reserved code 11 falls back to the register-file value.
  function automatic logic [WIDTH-1:0] fwd_sel(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] regval,
    input logic [WIDTH-1:0] resw,
    input logic [WIDTH-1:0] alum
  );
    logic [WIDTH-1:0] res;
    case (sel)
      2'b00:   res = regval;
      2'b01:   res = resw;
      2'b10:   res = alum;
      default: res = regval;
    endcase
    return res;
  endfunction

  // Pipeline register: reset beats flush (bubble), flush beats stall, otherwise load.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      rd1_r       <= '0;
      rd2_r       <= '0;
      imm_r       <= '0;
      pc_r        <= '0;
      pcplus4_r   <= '0;
      rs1_r       <= '0;
      rs2_r       <= '0;
      rd_r        <= '0;
      regwrite_r  <= 1'b0;
      memwrite_r  <= 1'b0;
      jump_r      <= 1'b0;
      branch_r    <= 1'b0;
      alusrc_r    <= 1'b0;
      resultsrc_r <= 2'b00;
      aluctrl_r   <= 3'b000;
      valid_r     <= 1'b0;
    end else if (StallE) begin
      valid_r     <= valid_r;
    end else begin
      rd1_r       <= RD1D;
      rd2_r       <= RD2D;
      imm_r       <= ImmExtD;
      pc_r        <= PCD;
      pcplus4_r   <= PCPlus4D;
      rs1_r       <= Rs1D;
      rs2_r       <= Rs2D;
      rd_r        <= RdD;
      regwrite_r  <= RegWriteD;
      memwrite_r  <= MemWriteD;
      jump_r      <= JumpD;
      branch_r    <= BranchD;
      alusrc_r    <= ALUSrcD;
      resultsrc_r <= ResultSrcD;
      aluctrl_r   <= ALUControlD;
      valid_r     <= 1'b1;
    end
  end

  // Execute-stage operand selection and branch resolution; forwarding values are never registered.
  always_comb begin
    fwd_a_s  = fwd_sel(ForwardAE, rd1_r, ResultW, ALUResultM);
    fwd_b_s  = fwd_sel(ForwardBE, rd2_r, ResultW, ALUResultM);
    if (alusrc_r) begin
      srcb_s = imm_r;
    end else begin
      srcb_s = fwd_b_s;
    end
    target_s = pc_r + imm_r;
    pcsrc_s  = jump_r | (branch_r & ZeroE);
  end

  assign SrcAE       = fwd_a_s;
  assign SrcBE       = srcb_s;
  assign WriteDataE  = fwd_b_s;
  assign PCTargetE   = target_s;
  assign PCSrcE      = pcsrc_s;
  assign ALUControlE = aluctrl_r;
  assign RdE         = rd_r;
  assign Rs1E        = rs1_r;
  assign Rs2E        = rs2_r;
  assign PCPlus4E    = pcplus4_r;
  assign RegWriteE   = regwrite_r;
  assign MemWriteE   = memwrite_r;
  assign ResultSrcE  = resultsrc_r;
  assign ValidE      = valid_r;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus execute-stage operand selection for the 5-stage RISC-V pipeline.
- Captures decoded operands and control from Decode each cycle.
- Resolves forwarding to produce SrcA/SrcB/ALUControl for the ALU, then computes branch target and taken decision from the ALU Zero flag.
- Bubble insertion (FlushE) and hold (StallE) are driven by the hazard unit.

Parameters:
- WIDTH, 32, datapath/PC width.
- REGADDR, 5, register-index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- FlushE  in  1  load a bubble next edge.
- StallE  in  1  hold all E registers next edge.
- RD1D, RD2D  in  WIDTH each  register-file read data.
- ImmExtD, PCD, PCPlus4D  in  WIDTH each  immediate, PC, PC+4.
- Rs1D, Rs2D, RdD  in  REGADDR each  register indices.
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decoded control.
- ResultSrcD  in  2  writeback select.
- ALUControlD  in  3  ALU op (000 add, 001 sub, 010 and, 011 or, 101 slt).
- ForwardAE, ForwardBE  in  2 each  from hazard unit.
- ALUResultM, ResultW  in  WIDTH each  forwarding sources.
- ZeroE  in  1  ALU Zero flag (combinational from SrcAE/SrcBE).
- SrcAE, SrcBE  out  WIDTH each  ALU operands (combinational).
- ALUControlE  out  3  registered.
- WriteDataE  out  WIDTH  forwarded rs2 value for stores.
- PCTargetE  out  WIDTH  PCE + ImmExtE.
- PCSrcE  out  1  JumpE | (BranchE & ZeroE).
- RdE, Rs1E, Rs2E  out  REGADDR each  registered.
- PCPlus4E  out  WIDTH  registered.
- RegWriteE, MemWriteE  out  1 each  registered.
- ResultSrcE  out  2  registered.
- ValidE  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Register update priority per edge: reset > FlushE > StallE > load.
- reset or FlushE: every registered field cleared to 0, ValidE=0.
  - Bubble is therefore inert: RegWriteE=MemWriteE=JumpE=BranchE=0, ALUControlE=000, all operand/index fields 0.
- StallE (no flush/reset): all registers keep their value, ValidE included.
- Load: all D inputs captured; ValidE<=1.
- Latency: one cycle D->E for registered fields. SrcAE/SrcBE/WriteDataE/PCTargetE/PCSrcE are combinational from E registers and forwarding inputs, with no added cycle.
- SrcAE mux on ForwardAE:
  - 00 RD1E
  - 01 ResultW
  - 10 ALUResultM
  - 11 reserved, selects RD1E
- Forwarded B uses the same mapping on ForwardBE with RD2E.
- WriteDataE = forwarded B.
- SrcBE = ALUSrcE ? ImmExtE : forwarded B.
- PCTargetE = PCE + ImmExtE, truncated to WIDTH bits; overflow wraps, no flag.
- PCSrcE = JumpE | (BranchE & ZeroE). It is 0 during a bubble because JumpE and BranchE are cleared.
- FlushE and StallE both high: flush wins.
- Reset asserted mid-stall: register cleared on that edge; stall is ignored.
- Forwarding inputs are sampled combinationally only and are never registered here.

Test Plan:
- Reset: hold reset 2 cycles with nonzero D inputs -> all registered outputs 0, ValidE=0, PCSrcE=0, SrcAE=SrcBE=0 with ForwardAE/BE=00.
- Load and forward: RD1D=5, RD2D=7, ALUSrcD=0, ALUControlD=001, load.
  - ForwardAE=00 -> SrcAE=5, SrcBE=7.
  - ForwardAE=10 with ALUResultM=0x20 -> SrcAE=0x20.
  - ForwardBE=01 with ResultW=3 -> SrcBE=3 and WriteDataE=3.
- Immediate path: ALUSrcD=1, ImmExtD=0xFFFFFFFC, RD2D=9, ForwardBE=10, ALUResultM=0x44 -> SrcBE=0xFFFFFFFC, WriteDataE=0x44.
- Branch wrap: PCD=0x00000008, ImmExtD=0xFFFFFFF8, BranchD=1.
  - ZeroE=1 -> PCTargetE=0x00000000, PCSrcE=1.
  - ZeroE=0 -> PCSrcE=0.
  - JumpD=1 -> PCSrcE=1 regardless of ZeroE.
- Stall/flush: load RdD=10, then StallE=1 for 2 cycles with new D inputs (RdD=11) -> RdE stays 10. Then FlushE=StallE=1 -> next edge RdE=0, RegWriteE=0, ValidE=0.
- Reset mid-stall: StallE=1 with held valid instruction, assert reset one cycle -> ValidE=0, all fields 0. Deassert reset, next load captures D normally.
